// File: rtl/wb_keypad.sv
// Wishbone-attached 4x4 matrix keypad scanner with per-key debounce,
// a key-press event FIFO and a level interrupt.
module wb_keypad #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic        irq_o
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [AW-1:0]    PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [3:0]       CNT_FULL = 4'(FIFO_DEPTH);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SAMPLE, S_PROC0, S_PROC1, S_PROC2, S_PROC3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       row_meta, row_sync;
  logic [1:0]       col_idx;
  logic [DIV_W-1:0] div;
  logic [3:0]       sample;
  logic [15:0]      stable;
  logic [CNT_W-1:0] deb_cnt [16];

  logic             ctrl_en, ctrl_irq_en;
  logic             overflow;
  logic [3:0]       count;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [3:0]       mem [FIFO_DEPTH];
  logic             ack;

  logic             proc_act;
  logic [1:0]       proc_row;
  logic [3:0]       proc_key;
  logic             cur_smp, cur_stb, flip, push;
  logic [CNT_W-1:0] cur_cnt;

  logic             access, wr, rd, pop, do_push, full, not_empty;
  logic [31:0]      rd_data;

  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3]};

  // Scanner FSM: next state and per-cycle decode
  always_comb begin
    state_nxt = state;
    proc_act  = 1'b0;
    proc_row  = 2'd0;
    case (state)
      S_IDLE:   if (ctrl_en) state_nxt = S_WAIT;
      S_WAIT:   if (div == DIV_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_PROC0;
      S_PROC0:  begin proc_act = 1'b1; proc_row = 2'd0; state_nxt = S_PROC1; end
      S_PROC1:  begin proc_act = 1'b1; proc_row = 2'd1; state_nxt = S_PROC2; end
      S_PROC2:  begin proc_act = 1'b1; proc_row = 2'd2; state_nxt = S_PROC3; end
      S_PROC3:  begin proc_act = 1'b1; proc_row = 2'd3; state_nxt = S_WAIT; end
      default:  state_nxt = S_IDLE;
    endcase
    if (!ctrl_en) state_nxt = S_IDLE;
  end

  always_comb begin
    col_out = (state == S_IDLE) ? 4'b1111 : ~(4'b0001 << col_idx);
  end

  assign proc_key = {col_idx, proc_row};
  assign cur_smp  = sample[proc_row];
  assign cur_stb  = stable[proc_key];
  assign cur_cnt  = deb_cnt[proc_key];
  assign flip     = proc_act && (cur_smp != cur_stb) && (cur_cnt == CNT_LAST);
  assign push     = flip && cur_smp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Disabling the scanner wipes all key state so a re-enable starts clean
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_idx <= '0;
      div     <= '0;
      sample  <= '0;
      stable  <= '0;
      for (int unsigned k = 0; k < 16; k++) deb_cnt[k] <= '0;
    end else if (!ctrl_en) begin
      col_idx <= '0;
      div     <= '0;
      stable  <= '0;
      for (int unsigned k = 0; k < 16; k++) deb_cnt[k] <= '0;
    end else begin
      if (state == S_WAIT && div != DIV_LAST) div <= div + 1'b1;
      if (state == S_SAMPLE) sample <= ~row_sync;
      if (proc_act) begin
        if (cur_smp == cur_stb) begin
          deb_cnt[proc_key] <= '0;
        end else if (flip) begin
          deb_cnt[proc_key] <= '0;
          stable[proc_key]  <= cur_smp;
        end else begin
          deb_cnt[proc_key] <= cur_cnt + 1'b1;
        end
      end
      if (state == S_PROC3) begin
        col_idx <= col_idx + 1'b1;
        div     <= '0;
      end
    end
  end

  assign access    = wb_stb_i & wb_cyc_i & ~ack;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign not_empty = (count != 4'd0);
  assign full      = (count == CNT_FULL);
  assign pop       = rd && (wb_adr_i[3:2] == A_DATA) && not_empty;
  assign do_push   = push && !full;
  assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack;

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[3:2])
      A_STATUS: rd_data = {24'd0, count, 1'b0, overflow, full, not_empty};
      A_DATA:   rd_data = not_empty ? {27'd0, 1'b1, mem[rd_ptr]} : '0;
      A_CTRL:   rd_data = {30'd0, ctrl_irq_en, ctrl_en};
      default:  rd_data = {16'd0, stable};
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= proc_key;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack         <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      irq_o       <= 1'b0;
    end else begin
      ack <= access;
      if (access) wb_dat_o <= wb_we_i ? '0 : rd_data;
      if (wr && wb_adr_i[3:2] == A_CTRL) begin
        ctrl_en     <= wb_dat_i[0];
        ctrl_irq_en <= wb_dat_i[1];
      end
      if (push && full) begin
        overflow <= 1'b1;
      end else if (wr && wb_adr_i[3:2] == A_STATUS && wb_dat_i[2]) begin
        overflow <= 1'b0;
      end
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      irq_o <= ctrl_irq_en & not_empty;
    end
  end

endmodule

// File: tb/tb_wb_keypad.sv
// Self-checking bench for wb_keypad: a keypad matrix model drives row_in
// from col_out, and an event-level FIFO model predicts register contents.
module tb_wb_keypad;
  localparam int unsigned SCAN_DIV    = 8;
  localparam int unsigned DEB         = 2;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned SCAN_CYCLES = 4 * (SCAN_DIV + 5);
  localparam int unsigned HOLD        = 4 * SCAN_CYCLES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '1;
  logic [31:0] dat_o;
  logic        ack, irq;
  logic [3:0]  col_out, row_in;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_q[$];
  bit          exp_ovf = 1'b0;
  logic [31:0] exp_raw = '0;

  wb_keypad #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_ack_o(ack),
    .col_out(col_out), .row_in(row_in), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column line to its row line
  always_comb begin
    row_in = '1;
    for (int c = 0; c < 4; c++)
      if (!col_out[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_in[r] = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_press(input int k);
    if (exp_q.size() < DEPTH) exp_q.push_back(k);
    else exp_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return 32'((n << 4) | (exp_ovf ? 4 : 0) | ((n == DEPTH) ? 2 : 0) | ((n > 0) ? 1 : 0));
  endfunction

  function automatic logic [31:0] exp_pop();
    int k;
    if (exp_q.size() == 0) return '0;
    k = exp_q.pop_front();
    return 32'h10 | 32'(k);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
    bit got;
    @(posedge clk); #1;
    adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    got = 1'b0;
    d = 'x;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin d = dat_o; got = 1'b1; end
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wb_read_timeout adr=%h: no ack within 10 cycles", a);
    end
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(posedge clk); #1;
    adr = a; dat_i = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wb_write_timeout adr=%h: no ack within 10 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    idle(3);
    n_checks++;
    if (col_out !== 4'hF || irq !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: col_out=%h irq=%b ack=%b, required F 0 0", col_out, irq, ack);
    end
    reset_n = 1'b1;
    for (int unsigned a = 0; a < 16; a += 4) begin
      wb_rd(a, d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read adr=%h: got %h, required 0", a, d);
      end
    end
  endtask

  task automatic test_single_press();
    logic [31:0] d, e;
    wb_wr(32'h8, 32'h3);
    keys[9] = 1'b1;
    idle(HOLD);
    model_press(9);
    exp_raw = 32'h200;
    wb_rd(32'hC, d);
    n_checks++;
    if (d !== exp_raw) begin n_fail++; $display("FAIL press_raw: got %h, required %h", d, exp_raw); end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL press_status: got %h, required %h", d, e); end
    idle(2);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b, required 1", irq); end
    wb_rd(32'h4, d); e = exp_pop();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL press_data: got %h, required %h", d, e); end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL pop_status: got %h, required %h", d, e); end
    idle(2);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pop_irq: got %b, required 0", irq); end
    keys[9] = 1'b0;
    idle(HOLD);
    exp_raw = '0;
    wb_rd(32'hC, d);
    n_checks++;
    if (d !== exp_raw) begin n_fail++; $display("FAIL release_raw: got %h, required %h", d, exp_raw); end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL release_no_push: status %h, required %h", d, e); end
  endtask

  task automatic test_two_keys();
    logic [31:0] d, e;
    keys[0] = 1'b1; keys[3] = 1'b1;
    idle(HOLD);
    model_press(0); model_press(3);
    exp_raw = 32'h9;
    wb_rd(32'hC, d);
    n_checks++;
    if (d !== exp_raw) begin n_fail++; $display("FAIL two_raw: got %h, required %h", d, exp_raw); end
    for (int i = 0; i < 2; i++) begin
      wb_rd(32'h4, d); e = exp_pop();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL two_data%0d: got %h, required %h", i, d, e); end
    end
    keys[0] = 1'b0; keys[3] = 1'b0;
    exp_raw = '0;
    idle(HOLD);
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    int k, c;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      k = int'($urandom_range(15));
      c = k / 4;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        if (col_out[c]) ok = 1'b1; else idle(1);
      end
      for (int i = 0; i < 200 && ok; i++) begin
        if (!col_out[c]) ok = 1'b0; else idle(1);
      end
      n_checks++;
      if (ok) begin n_fail++; $display("FAIL glitch_col_wait: column %0d never driven, required low", c); end
      keys[k] = 1'b1;
      idle(SCAN_DIV + 5);
      keys[k] = 1'b0;
      idle(2 * SCAN_CYCLES);
      wb_rd(32'hC, d);
      n_checks++;
      if (d !== exp_raw) begin n_fail++; $display("FAIL glitch_raw key %0d: got %h, required %h", k, d, exp_raw); end
      wb_rd(32'h0, d); e = exp_status();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL glitch_status key %0d: got %h, required %h", k, d, e); end
    end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] d, e;
    for (int i = 0; i < 3; i++) begin
      wb_wr(32'h4, $urandom);
      wb_wr(32'hC, $urandom);
      wb_wr(32'h8, $urandom | 32'h3);
      wb_rd(32'h8, d);
      n_checks++;
      if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_readback: got %h, required 3", d); end
      wb_rd(32'h0, d); e = exp_status();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL ignored_write_status: got %h, required %h", d, e); end
      wb_rd(32'hC, d);
      n_checks++;
      if (d !== exp_raw) begin n_fail++; $display("FAIL ignored_write_raw: got %h, required %h", d, exp_raw); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    int order[16];
    int j, t;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 9; i++) begin
      keys[order[i]] = 1'b1;
      idle(HOLD);
      keys[order[i]] = 1'b0;
      idle(HOLD);
      model_press(order[i]);
    end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL overflow_status: got %h, required %h", d, e); end
    wb_wr(32'h0, 32'h4);
    exp_ovf = 1'b0;
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL overflow_clear: got %h, required %h", d, e); end
    for (int i = 0; i < 8; i++) begin
      wb_rd(32'h4, d); e = exp_pop();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL fifo_order%0d: got %h, required %h", i, d, e); end
    end
    wb_rd(32'h4, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h, required 0", d); end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL empty_status: got %h, required %h", d, e); end
  endtask

  task automatic test_back_to_back();
    int acks;
    @(posedge clk); #1;
    adr = 32'h8; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        n_checks++;
        if (dat_o !== 32'h3) begin n_fail++; $display("FAIL b2b_data: got %h, required 3", dat_o); end
      end
    end
    stb = 1'b0; cyc = 1'b0;
    n_checks++;
    if (acks != 4) begin n_fail++; $display("FAIL b2b_acks: got %0d acks in 8 cycles, required 4", acks); end
  endtask

  task automatic test_enable_clear();
    logic [31:0] d, e;
    logic [3:0]  prev;
    int k;
    bit seen;
    k = int'($urandom_range(15));
    keys[k] = 1'b1;
    idle(HOLD);
    model_press(k);
    exp_raw = 32'h1 << k;
    wb_rd(32'hC, d);
    n_checks++;
    if (d !== exp_raw) begin n_fail++; $display("FAIL en_raw_before key %0d: got %h, required %h", k, d, exp_raw); end
    prev = col_out;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle(1);
      if (col_out !== prev) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL en_col_step: col_out stuck at %h, required a change", col_out); end
    wb_wr(32'h8, 32'h0);
    n_checks++;
    if (col_out === 4'hF) begin n_fail++; $display("FAIL en_col_still_driven: got %h, required a driven column", col_out); end
    idle(1);
    n_checks++;
    if (col_out !== 4'hF) begin n_fail++; $display("FAIL en_col_idle: got %h, required F", col_out); end
    exp_raw = '0;
    wb_rd(32'hC, d);
    n_checks++;
    if (d !== exp_raw) begin n_fail++; $display("FAIL en_raw_cleared: got %h, required 0", d); end
    wb_rd(32'h0, d); e = exp_status();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL en_status_kept: got %h, required %h", d, e); end
    wb_rd(32'h4, d); e = exp_pop();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL en_data_kept: got %h, required %h", d, e); end
    keys[k] = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    wb_wr(32'h8, 32'h3);
    keys[5] = 1'b1;
    idle(HOLD);
    model_press(5);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL prereset_irq: got %b, required 1", irq); end
    @(posedge clk); #1;
    adr = 32'h0; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL prereset_ack: got %b, required 1", ack); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0 || col_out !== 4'hF) begin
      n_fail++;
      $display("FAIL async_reset: ack=%b dat=%h irq=%b col=%h, required 0 0 0 F", ack, dat_o, irq, col_out);
    end
    stb = 1'b0; cyc = 1'b0;
    keys[5] = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; exp_raw = '0;
    idle(2);
    reset_n = 1'b1;
    wb_rd(32'h8, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL postreset_ctrl: got %h, required 0", d); end
    wb_rd(32'h0, d);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL postreset_status: got %h, required %h", d, exp_status()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_two_keys();
    test_glitch();
    test_ignored_writes();
    test_overflow();
    test_back_to_back();
    test_enable_clear();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
